// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the PC, drives the instruction-memory address and predicts taken
// branches with a 16-entry direct-mapped BTB trained by the execute stage.
module fetch_stage #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [12:0] RESET_PC    = 13'h0000
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        stall,
  input  logic        fail_predict,
  input  logic [12:0] redirect_pc,
  output logic [12:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [12:0] pcF,
  output logic [31:0] instF,
  output logic        predict_taken,
  input  logic        upd_en,
  input  logic [12:0] upd_pc,
  input  logic        upd_taken,
  input  logic [12:0] upd_target
);

  // Counter value written on a fresh allocation and after reset.
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [1:0] CTR_RESET = 2'b01;

  // Program counter.
  logic [12:0] r_pc;
  logic [12:0] w_pc_next;

  // BTB state: valid/ctr need reset values, tag/target do not.
  logic [BTB_ENTRIES-1:0]      r_valid;
  logic [BTB_ENTRIES-1:0][1:0] r_ctr;
  logic [6:0]                  r_tag    [BTB_ENTRIES];
  logic [12:0]                 r_target [BTB_ENTRIES];

  // Lookup side (current PC).
  logic [3:0]  w_idx;
  logic        w_hit;
  logic        w_pred;

  // Update side (resolved branch from execute).
  logic [3:0]  w_upd_idx;
  logic        w_upd_hit;
  logic [1:0]  w_upd_ctr;
  logic [12:0] w_redirect_aligned;
  logic [12:0] w_target_aligned;

  // Low address bits are architecturally zero; collected here so they are
  // visibly consumed.
  logic w_unused;
  assign w_unused = &{1'b0, redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign w_redirect_aligned = {redirect_pc[12:2], 2'b00};
  assign w_target_aligned   = {upd_target[12:2], 2'b00};

  // Combinational lookup on the registered PC; no bypass from the update port.
  assign w_idx  = r_pc[5:2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == r_pc[12:6]);
  assign w_pred = w_hit && r_ctr[w_idx][1];

  assign w_upd_idx = upd_pc[5:2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == upd_pc[12:6]);

  // Fetch outputs are a zero-latency view of the PC and memory.
  assign imem_addr     = r_pc;
  assign pcF           = r_pc;
  assign instF         = imem_rdata;
  assign predict_taken = w_pred;

  // Next-PC selection: redirect > stall > predicted target > sequential.
  always_comb begin
    // NOTE: default assignment first so every path drives w_pc_next; a missing branch would infer a latch.
    w_pc_next = r_pc + 13'd4;
    if (fail_predict) begin
      w_pc_next = w_redirect_aligned;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (w_pred) begin
      w_pc_next = r_target[w_idx];
    end
  end

  // Saturating counter step for a hit update.
  always_comb begin
    w_upd_ctr = r_ctr[w_upd_idx];
    if (upd_taken) begin
      if (r_ctr[w_upd_idx] != 2'b11) w_upd_ctr = r_ctr[w_upd_idx] + 2'd1;
    end else begin
      if (r_ctr[w_upd_idx] != 2'b00) w_upd_ctr = r_ctr[w_upd_idx] - 2'd1;
    end
  end

  // PC register with asynchronous reset.
  always_ff @(posedge CLK or negedge NRST) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values together.
    if (!NRST) begin
      r_pc <= {RESET_PC[12:2], 2'b00};
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // BTB valid bits and direction counters; trained regardless of stall/redirect.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_valid <= '0;
      r_ctr   <= {BTB_ENTRIES{CTR_RESET}};
    end else if (upd_en) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_upd_ctr;
      end else if (upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // BTB tag/target storage, written on any taken update (hit or allocate).
  // NOTE: no reset on this array; entries are qualified by r_valid, so their contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (upd_en && upd_taken) begin
      r_tag[w_upd_idx]    <= upd_pc[12:6];
      r_target[w_upd_idx] <= w_target_aligned;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
// Each step pushes the expected post-edge PC/prediction; the entry is popped
// and compared once the edge has passed.
module tb_fetch_stage;

  logic        CLK;
  logic        NRST;
  logic        stall;
  logic        fail_predict;
  logic [12:0] redirect_pc;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [12:0] pcF;
  logic [31:0] instF;
  logic        predict_taken;
  logic        upd_en;
  logic [12:0] upd_pc;
  logic        upd_taken;
  logic [12:0] upd_target;

  typedef struct {
    string       tag;
    logic [12:0] pc;
    logic        pt;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  fetch_stage #(.BTB_ENTRIES(16), .RESET_PC(13'h0000)) dut (
    .CLK          (CLK),
    .NRST         (NRST),
    .stall        (stall),
    .fail_predict (fail_predict),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pcF          (pcF),
    .instF        (instF),
    .predict_taken(predict_taken),
    .upd_en       (upd_en),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory model: word derived from its address.
  function automatic logic [31:0] mem_word(input logic [12:0] a);
    return {a ^ 13'h1ABC, 6'h2A, a};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop one scoreboard entry and compare all fetch outputs against it.
  task automatic compare_front();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".pcF"},  {19'd0, pcF},       {19'd0, e.pc});
    check({e.tag, ".addr"}, {19'd0, imem_addr}, {19'd0, e.pc});
    check({e.tag, ".inst"}, instF,              mem_word(e.pc));
    check({e.tag, ".pred"}, {31'd0, predict_taken}, {31'd0, e.pt});
  endtask

  task automatic drive(input logic st, input logic fp, input logic [12:0] rpc,
                       input logic ue, input logic [12:0] upc, input logic ut,
                       input logic [12:0] utgt);
    stall        = st;
    fail_predict = fp;
    redirect_pc  = rpc;
    upd_en       = ue;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
  endtask

  // Push expectation, take one edge, then compare.
  task automatic tick(input string tag, input logic [12:0] epc, input logic ept);
    exp_t e;
    e.tag = tag; e.pc = epc; e.pt = ept;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    compare_front();
  endtask

  task automatic step(input string tag, input logic st, input logic fp, input logic [12:0] rpc,
                      input logic ue, input logic [12:0] upc, input logic ut,
                      input logic [12:0] utgt, input logic [12:0] epc, input logic ept);
    drive(st, fp, rpc, ue, upc, ut, utgt);
    tick(tag, epc, ept);
  endtask

  // Compare current outputs without an edge.
  task automatic expect_now(input string tag, input logic [12:0] epc, input logic ept);
    exp_t e;
    e.tag = tag; e.pc = epc; e.pt = ept;
    sb_q.push_back(e);
    compare_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    NRST = 1'b0;
    drive(0, 0, 13'h0, 0, 13'h0, 0, 13'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    expect_now("reset", 13'h0000, 1'b0);
    NRST = 1'b1;

    // Sequential fetch.
    step("seq1", 0, 0, 0, 0, 0, 0, 0, 13'h0004, 0);
    step("seq2", 0, 0, 0, 0, 0, 0, 0, 13'h0008, 0);
    step("seq3", 0, 0, 0, 0, 0, 0, 0, 13'h000C, 0);

    // Asynchronous reset in mid-cycle.
    #3;
    NRST = 1'b0;
    #1;
    expect_now("async_rst", 13'h0000, 1'b0);
    @(posedge CLK);
    #1;
    NRST = 1'b1;
    expect_now("rst_rel", 13'h0000, 1'b0);
    step("seq4", 0, 0, 0, 0, 0, 0, 0, 13'h0004, 0);
    step("seq5", 0, 0, 0, 0, 0, 0, 0, 13'h0008, 0);

    // Stall for three cycles, then stall with redirect, then wrap.
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0, 0, 0, 0, 13'h0008, 0);
    step("st_redir", 1, 1, 13'h0123, 0, 0, 0, 0, 13'h0120, 0);
    step("redir_top", 0, 1, 13'h1FFC, 0, 0, 0, 0, 13'h1FFC, 0);
    step("wrap", 0, 0, 0, 0, 0, 0, 0, 13'h0000, 0);

    // Allocate 0x0010 -> 0x0100, then fetch through it.
    step("alloc", 0, 0, 0, 1, 13'h0010, 1, 13'h0100, 13'h0004, 0);
    step("to8", 0, 0, 0, 0, 0, 0, 0, 13'h0008, 0);
    step("toC", 0, 0, 0, 0, 0, 0, 0, 13'h000C, 0);
    step("hit10", 0, 0, 0, 0, 0, 0, 0, 13'h0010, 1);
    step("tgt100", 0, 0, 0, 0, 0, 0, 0, 13'h0100, 0);

    // Not-taken miss update does not allocate.
    step("nt_miss", 0, 1, 13'h001C, 1, 13'h0020, 0, 13'h0300, 13'h001C, 0);
    step("at20", 0, 0, 0, 0, 0, 0, 0, 13'h0020, 0);
    step("at24", 0, 0, 0, 0, 0, 0, 0, 13'h0024, 0);

    // Counter training: 2 -> 1 falls through.
    step("dec1", 0, 0, 0, 1, 13'h0010, 0, 0, 13'h0028, 0);
    step("ret10a", 0, 1, 13'h0010, 0, 0, 0, 0, 13'h0010, 0);
    step("fall14", 0, 0, 0, 0, 0, 0, 0, 13'h0014, 0);
    // Three taken updates (1->2->3->3) with a new target, then one not-taken (3->2).
    step("inc1", 0, 0, 0, 1, 13'h0010, 1, 13'h0200, 13'h0018, 0);
    step("inc2", 0, 0, 0, 1, 13'h0010, 1, 13'h0200, 13'h001C, 0);
    step("inc3", 0, 0, 0, 1, 13'h0010, 1, 13'h0200, 13'h0020, 0);
    step("dec2", 0, 0, 0, 1, 13'h0010, 0, 0, 13'h0024, 0);
    step("ret10b", 0, 1, 13'h0010, 0, 0, 0, 0, 13'h0010, 1);
    step("tgt200", 0, 0, 0, 0, 0, 0, 0, 13'h0200, 0);

    // Aliasing: 0x0050 shares index 4 with 0x0010.
    step("alias50", 0, 1, 13'h0050, 0, 0, 0, 0, 13'h0050, 0);
    step("alias54", 0, 0, 0, 0, 0, 0, 0, 13'h0054, 0);
    step("repl50", 0, 0, 0, 1, 13'h0050, 1, 13'h0300, 13'h0058, 0);
    step("old10", 0, 1, 13'h0010, 0, 0, 0, 0, 13'h0010, 0);
    step("old14", 0, 0, 0, 0, 0, 0, 0, 13'h0014, 0);
    step("new50", 0, 1, 13'h0050, 0, 0, 0, 0, 13'h0050, 1);
    step("tgt300", 0, 0, 0, 0, 0, 0, 0, 13'h0300, 0);

    // Same-cycle allocate and lookup at 0x0030: no bypass.
    step("at30", 0, 1, 13'h0030, 0, 0, 0, 0, 13'h0030, 0);
    drive(0, 0, 0, 1, 13'h0030, 1, 13'h0400);
    #1;
    expect_now("same_cyc", 13'h0030, 0);
    tick("same_nxt", 13'h0034, 0);
    step("ret30", 0, 1, 13'h0030, 0, 0, 0, 0, 13'h0030, 1);
    // Stall at a predicted PC keeps the prediction steady.
    step("st30", 1, 0, 0, 0, 0, 0, 0, 13'h0030, 1);
    step("tgt400", 0, 0, 0, 0, 0, 0, 0, 13'h0400, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter, drives the instruction-memory address, and presents `pcF`/`instF` to the fetch-to-decode pipeline register. It holds on `stall`, redirects on `fail_predict`, and predicts taken branches with a small direct-mapped branch target buffer (BTB). The execute stage trains the BTB.

## Interface
Parameters:
- `BTB_ENTRIES`, 16: number of BTB entries. Fixed at 16; the index is `pc[5:2]` and the tag is `pc[12:6]`.
- `RESET_PC`, 13'h0000: PC value after reset. Must be word-aligned.

Ports:
- `CLK`  in  1: clock, rising edge.
- `NRST`  in  1: reset, asynchronous, active-low.
- `stall`  in  1: hold the PC (same signal as the decode register's stall).
- `fail_predict`  in  1: misprediction; load `redirect_pc`.
- `redirect_pc`  in  13: correct next PC on misprediction.
- `imem_addr`  out  13: instruction-memory byte address.
- `imem_rdata`  in  32: instruction word; combinational read of `imem_addr`.
- `pcF`  out  13: PC of the fetched instruction.
- `instF`  out  32: fetched instruction.
- `predict_taken`  out  1: BTB predicted taken for `pcF`.
- `upd_en`  in  1: BTB update strobe from execute.
- `upd_pc`  in  13: PC of the resolved branch.
- `upd_taken`  in  1: resolved direction.
- `upd_target`  in  13: resolved branch target.

## Operation
**Outputs**
- `imem_addr = pcF = pc`.
- `instF = imem_rdata`.

**PC rules**
- Bits [1:0] of the PC are always 0.
- `redirect_pc[1:0]` and `upd_target[1:0]` are ignored and forced to 0.

**BTB entry format**
- `valid` (1 bit), `tag` (7 bits), `target` (13 bits), `ctr` (2-bit saturating counter).

**Lookup (combinational, on the current `pc`)**
- Hit when `valid[idx]` is set and `tag[idx] == pc[12:6]`, where `idx = pc[5:2]`.
- `predict_taken = hit & ctr[idx][1]`.

**Next-PC priority**
1. `fail_predict` → `redirect_pc`.
2. `stall` → `pc` (hold).
3. `predict_taken` → `target[idx]`.
4. Otherwise → `pc + 4`, modulo 2^13. 0x1FFC wraps to 0x0000.

**Update (on a clock edge with `upd_en` = 1)**
- On a hit at `upd_pc`:
  - `ctr` increments if `upd_taken`, otherwise decrements; saturates at 3 and at 0.
  - `target` is overwritten with `upd_target` when `upd_taken`.
- On a miss with `upd_taken` = 1: allocate the entry, overwriting any existing one. Set `valid` = 1, `tag = upd_pc[12:6]`, `target = upd_target`, `ctr` = 2'b10.
- On a miss with `upd_taken` = 0: no change.

**Reset and simultaneous events**
- Reset clears all `valid` bits, sets all `ctr` to 2'b01, and sets `pc = RESET_PC`.
- Reset asserted mid-operation takes effect immediately, independent of `CLK`.
- Update and lookup in the same cycle: lookup sees the pre-update BTB state. There is no bypass.
- `upd_en` is independent of `stall` and `fail_predict`. Updates are applied even while stalled or redirecting.

## Timing
- PC register: a single level. Each next-PC choice takes effect at the next rising edge.
- Fetch path: zero-latency combinational path from `pc` to `imem_addr`, `pcF`, `instF` and `predict_taken`.
- Redirect: `fail_predict` asserted in cycle N → `pc = redirect_pc` in cycle N+1. The decode register flushes in the same edge.
- Stall: a stall held for k cycles keeps `pc`, `imem_addr` and `predict_taken` constant for k cycles.
- Training: an update written at edge N is visible to a lookup from cycle N+1 onward.
- Reset values:
  - `pc` = `imem_addr` = `pcF` = `RESET_PC`.
  - `predict_taken` = 0.
  - `instF` follows memory.

## Test plan
- **Reset and sequential fetch.** Assert `NRST` = 0 asynchronously mid-cycle → `pcF` = 0x0000 and `predict_taken` = 0 immediately. After release, `pcF` = 0x0000, 0x0004, 0x0008 on successive cycles, and `instF` matches memory.
- **Stall, redirect and wrap.**
  - `stall` = 1 for 3 cycles at 0x0008 → `pcF` stays 0x0008.
  - `stall` = 1 with `fail_predict` = 1 and `redirect_pc` = 0x0123 → next `pcF` = 0x0120.
  - `redirect_pc` = 0x1FFC → the following `pcF` = 0x0000 (wrap).
- **BTB allocate and predict.**
  - Apply `upd_en` with `upd_pc` = 0x0010, `upd_taken` = 1, `upd_target` = 0x0100.
  - Then fetch through 0x0010 → `predict_taken` = 1 at 0x0010, and the next `pcF` = 0x0100.
  - A not-taken miss update to 0x0020 leaves 0x0020 unpredicted.
- **Counter training.**
  - After allocation (`ctr` = 2), one not-taken update → `ctr` = 1, so 0x0010 falls through to 0x0014.
  - Three taken updates → `ctr` saturates at 3; one not-taken update → `ctr` = 2, still predicted taken.
- **Aliasing.** With the entry for 0x0010 valid, fetching 0x0050 (same index, tag 1 vs 0) → `predict_taken` = 0 and next `pcF` = 0x0054. A taken update at 0x0050 replaces the entry, so 0x0010 then misses.
- **Same-cycle update and lookup.** With `pc` = 0x0030 and a same-cycle allocate for 0x0030 → `predict_taken` = 0 in that cycle. Once the PC returns to 0x0030 after a redirect, it is predicted taken.
